// File: rtl/datapath_if.sv
// Control and memory bus between the multicycle controller/memory and the
// datapath. The controller side drives control lines and memory read data;
// the datapath drives the memory address/write data and decode outputs.
interface datapath_if;
  logic        pcen;
  logic        irwrite;
  logic        regwrite;
  logic        alusrca;
  logic        iord;
  logic        memtoreg;
  logic        regdst;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  modport master (
    output pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol, readdata,
    input  adr, writedata, op, funct, zero
  );

  modport slave (
    input  pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol, readdata,
    output adr, writedata, op, funct, zero
  );
endinterface

// File: rtl/datapath.sv
// Multicycle MIPS-style datapath: PC, instruction/data registers, A/B
// operand registers, ALUOut, a 32x32 register file and the ALU.
// Register file reads are combinational with no write bypass; register 0
// always reads as zero. The register file itself is never reset.
module datapath (
  input  logic      clk,
  input  logic      reset,
  datapath_if.slave bus
);

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] data_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] aluout_r;
  logic [31:0] rf_r [32];

  logic [4:0]  ra1_s;
  logic [4:0]  ra2_s;
  logic [4:0]  wa_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] wd_s;
  logic [31:0] signimm_s;
  logic [31:0] signimmsh_s;
  logic [31:0] jump_s;
  logic [31:0] srca_s;
  logic [31:0] srcb_s;
  logic [31:0] bmod_s;
  logic [31:0] sum_s;
  logic        sub_s;
  logic        slt_s;
  logic [31:0] alures_s;
  logic [31:0] pcnext_s;

  // Field extraction and immediate / jump target formation
  assign ra1_s       = instr_r[25:21];
  assign ra2_s       = instr_r[20:16];
  assign signimm_s   = {{16{instr_r[15]}}, instr_r[15:0]};
  assign signimmsh_s = {signimm_s[29:0], 2'b00};
  assign jump_s      = {pc_r[31:28], instr_r[25:0], 2'b00};

  // Register file read ports; register 0 is hard-wired to zero
  always_comb begin
    rd1_s = 32'd0;
    rd2_s = 32'd0;
    if (ra1_s == 5'd0) begin
      rd1_s = 32'd0;
    end else begin
      rd1_s = rf_r[ra1_s];
    end
    if (ra2_s == 5'd0) begin
      rd2_s = 32'd0;
    end else begin
      rd2_s = rf_r[ra2_s];
    end
  end

  // Write-back destination and data selection
  always_comb begin
    wa_s = 5'd0;
    wd_s = 32'd0;
    if (bus.regdst) begin
      wa_s = instr_r[15:11];
    end else begin
      wa_s = instr_r[20:16];
    end
    if (bus.memtoreg) begin
      wd_s = data_r;
    end else begin
      wd_s = aluout_r;
    end
  end

  // ALU operand selection
  always_comb begin
    srca_s = 32'd0;
    srcb_s = 32'd0;
    if (bus.alusrca) begin
      srca_s = a_r;
    end else begin
      srca_s = pc_r;
    end
    case (bus.alusrcb)
      2'b00:   srcb_s = b_r;
      2'b01:   srcb_s = 32'd4;
      2'b10:   srcb_s = signimm_s;
      2'b11:   srcb_s = signimmsh_s;
      default: srcb_s = b_r;
    endcase
  end

  // Shared adder: subtraction as A + ~B + 1, also used for the SLT compare
  assign sub_s  = (bus.alucontrol == 3'b110) || (bus.alucontrol == 3'b111);
  assign bmod_s = sub_s ? ~srcb_s : srcb_s;
  assign sum_s  = srca_s + bmod_s + {31'd0, sub_s};
  // Signed less-than: differing signs decide directly, otherwise the
  // difference sign bit is exact because the subtraction cannot overflow
  assign slt_s  = (srca_s[31] != srcb_s[31]) ? srca_s[31] : sum_s[31];

  // ALU function select; unlisted codes behave as ADD
  always_comb begin
    alures_s = sum_s;
    case (bus.alucontrol)
      3'b000:  alures_s = srca_s & srcb_s;
      3'b001:  alures_s = srca_s | srcb_s;
      3'b010:  alures_s = sum_s;
      3'b110:  alures_s = sum_s;
      3'b111:  alures_s = {31'd0, slt_s};
      default: alures_s = sum_s;
    endcase
  end

  // Next-PC selection
  always_comb begin
    pcnext_s = alures_s;
    case (bus.pcsrc)
      2'b00:   pcnext_s = alures_s;
      2'b01:   pcnext_s = aluout_r;
      2'b10:   pcnext_s = jump_s;
      2'b11:   pcnext_s = alures_s;
      default: pcnext_s = alures_s;
    endcase
  end

  // Program counter, loaded only when enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= 32'd0;
    end else if (bus.pcen) begin
      pc_r <= pcnext_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction register, loaded from memory only when enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r <= 32'd0;
    end else if (bus.irwrite) begin
      instr_r <= bus.readdata;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Non-architectural stage registers, loaded unconditionally every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r   <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      aluout_r <= 32'd0;
    end else begin
      data_r   <= bus.readdata;
      a_r      <= rd1_s;
      b_r      <= rd2_s;
      aluout_r <= alures_s;
    end
  end

  // Register file write port; contents survive reset, register 0 is read-only
  always_ff @(posedge clk) begin
    if (bus.regwrite && (wa_s != 5'd0)) begin
      rf_r[wa_s] <= wd_s;
    end
  end

  // Memory-side and decode outputs
  assign bus.adr       = bus.iord ? aluout_r : pc_r;
  assign bus.writedata = b_r;
  assign bus.op        = instr_r[31:26];
  assign bus.funct     = instr_r[5:0];
  assign bus.zero      = (alures_s == 32'd0);

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the multicycle datapath. Expected values are
// pushed onto a scoreboard queue as stimulus is driven and popped when the
// corresponding DUT output is sampled (1 time unit after the clock edge).
module tb_datapath;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  datapath_if bus();

  datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pcen       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b010;
    bus.readdata   = 32'd0;
  endtask

  task automatic set_instr(input logic [31:0] w);
    bus.readdata = w;
    bus.irwrite  = 1'b1;
    tick();
    bus.irwrite  = 1'b0;
  endtask

  // Writes an arbitrary 32-bit value through the Data register path
  task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
    bus.pcen = 1'b0;
    set_instr({6'h23, 5'd0, idx, 16'h0000});
    bus.readdata = val;
    tick();
    bus.memtoreg = 1'b1;
    bus.regdst   = 1'b0;
    bus.regwrite = 1'b1;
    tick();
    bus.regwrite = 1'b0;
    bus.memtoreg = 1'b0;
  endtask

  // Loads an R-type instruction and lets A/B pick up RF[rs]/RF[rt]
  task automatic select_regs(input logic [4:0] rs, input logic [4:0] rt);
    set_instr({6'h00, rs, rt, 5'd0, 5'd0, 6'h20});
    tick();
  endtask

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    #2 reset = 1'b0;
    #2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL reset_adr got %h want %h", bus.adr, e); end
    e = exp_q.pop_front(); n_vec++;
    if (bus.writedata !== e) begin n_err++; $display("FAIL reset_writedata got %h want %h", bus.writedata, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.op} !== e) begin n_err++; $display("FAIL reset_op got %h want %h", bus.op, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.funct} !== e) begin n_err++; $display("FAIL reset_funct got %h want %h", bus.funct, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL reset_zero got %b want %h", bus.zero, e); end
    // Clock edges while held in reset must not load anything
    bus.pcen = 1'b1; bus.irwrite = 1'b1; bus.alusrcb = 2'b01; bus.readdata = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({bus.op, bus.funct, bus.adr[19:0]} !== e) begin n_err++; $display("FAIL reset_hold got %h/%h/%h want %h", bus.op, bus.funct, bus.adr, e); end
    idle();
  endtask

  task automatic fetch(input logic [31:0] w);
    bus.readdata = w; bus.irwrite = 1'b1; bus.pcen = 1'b1;
    bus.alusrca = 1'b0; bus.alusrcb = 2'b01; bus.alucontrol = 3'b010;
    bus.pcsrc = 2'b00; bus.iord = 1'b0;
  endtask

  task automatic test_fetch();
    #1 reset = 1'b1;
    fetch(32'h2008_0005);
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL fetch_first_adr got %h want %h", bus.adr, e); end
    exp_q.push_back(32'h4); exp_q.push_back(32'h08); exp_q.push_back(32'h05);
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL fetch_pc got %h want %h", bus.adr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.op} !== e) begin n_err++; $display("FAIL fetch_op got %h want %h", bus.op, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.funct} !== e) begin n_err++; $display("FAIL fetch_funct got %h want %h", bus.funct, e); end
  endtask

  task automatic test_addi();
    tick();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
    exp_q.push_back(32'h0); exp_q.push_back(32'h5);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL addi_zero got %b want %h", bus.zero, e); end
    tick();
    bus.iord = 1'b1; #1;
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL addi_aluout got %h want %h", bus.adr, e); end
    bus.regdst = 1'b0; bus.memtoreg = 1'b0; bus.regwrite = 1'b1;
    tick();
    idle();
    select_regs(5'd8, 5'd0);
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b010; bus.iord = 1'b1;
    exp_q.push_back(32'h5);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL addi_read_rf8 got %h want %h", bus.adr, e); end
    idle();
  endtask

  task automatic test_branch();
    load_reg(5'd8, 32'd7);
    load_reg(5'd9, 32'd7);
    fetch({6'h04, 5'd8, 5'd9, 16'h0003});
    exp_q.push_back(32'h8);
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL branch_pc8 got %h want %h", bus.adr, e); end
    bus.alusrca = 1'b0; bus.alusrcb = 2'b11; bus.alucontrol = 3'b010; bus.iord = 1'b1;
    exp_q.push_back(32'h14);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL branch_target got %h want %h", bus.adr, e); end
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b110;
    bus.pcsrc = 2'b01; bus.pcen = 1'b1; bus.iord = 1'b0;
    exp_q.push_back(32'h1); exp_q.push_back(32'h7); exp_q.push_back(32'h14);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL branch_zero got %b want %h", bus.zero, e); end
    e = exp_q.pop_front(); n_vec++;
    if (bus.writedata !== e) begin n_err++; $display("FAIL branch_writedata got %h want %h", bus.writedata, e); end
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL branch_pc got %h want %h", bus.adr, e); end
  endtask

  task automatic test_alu_corners();
    load_reg(5'd10, 32'hFFFF_FFFF);
    load_reg(5'd11, 32'h0000_0001);
    load_reg(5'd12, 32'h8000_0000);
    select_regs(5'd10, 5'd11);
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b111; bus.iord = 1'b1;
    exp_q.push_back(32'h1);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL slt_neg got %h want %h", bus.adr, e); end
    bus.alucontrol = 3'b010;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL add_wrap_zero got %b want %h", bus.zero, e); end
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL add_wrap got %h want %h", bus.adr, e); end
    select_regs(5'd12, 5'd12);
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b110;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL sub_min_zero got %b want %h", bus.zero, e); end
    idle();
  endtask

  task automatic test_alu_random();
    logic [2:0]  codes [6];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  c;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
    codes[3] = 3'b110; codes[4] = 3'b111; codes[5] = 3'b011;
    for (int i = 0; i < 10; i++) begin
      a = $urandom();
      b = $urandom();
      c = codes[$urandom_range(5, 0)];
      if (i == 0) begin b = a; c = 3'b110; end
      if (i == 1) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; c = 3'b111; end
      if (i == 2) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; c = 3'b111; end
      load_reg(5'd14, a);
      load_reg(5'd15, b);
      select_regs(5'd14, 5'd15);
      bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = c; bus.iord = 1'b1;
      r = alu_model(a, b, c);
      exp_q.push_back({31'd0, (r == 32'd0)});
      exp_q.push_back(r);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if ({31'd0, bus.zero} !== e) begin n_err++; $display("FAIL alu_rand_zero[%0d] op=%b got %b want %h", i, c, bus.zero, e); end
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (bus.adr !== e) begin n_err++; $display("FAIL alu_rand[%0d] a=%h b=%h op=%b got %h want %h", i, a, b, c, bus.adr, e); end
      idle();
    end
  endtask

  task automatic test_jump();
    load_reg(5'd13, 32'h4000_0010);
    select_regs(5'd13, 5'd0);
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b010;
    bus.pcsrc = 2'b00; bus.pcen = 1'b1;
    exp_q.push_back(32'h4000_0010);
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL jump_setup_pc got %h want %h", bus.adr, e); end
    set_instr(32'h0800_0100);
    exp_q.push_back(32'h02);
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.op} !== e) begin n_err++; $display("FAIL jump_op got %h want %h", bus.op, e); end
    bus.pcsrc = 2'b10; bus.pcen = 1'b1;
    exp_q.push_back(32'h4000_0400);
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL jump_pc got %h want %h", bus.adr, e); end
  endtask

  task automatic test_reg0_and_reset();
    load_reg(5'd0, 32'h0000_1234);
    select_regs(5'd0, 5'd0);
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b001; bus.iord = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL reg0_read got %h want %h", bus.adr, e); end
    idle();
    set_instr(32'hAD2A_0C2B);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL midreset_adr got %h want %h", bus.adr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.op} !== e) begin n_err++; $display("FAIL midreset_op got %h want %h", bus.op, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({26'd0, bus.funct} !== e) begin n_err++; $display("FAIL midreset_funct got %h want %h", bus.funct, e); end
    #1 reset = 1'b1;
    fetch(32'h2008_0005);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL refetch_adr got %h want %h", bus.adr, e); end
    tick();
    idle();
    e = exp_q.pop_front(); n_vec++;
    if (bus.adr !== e) begin n_err++; $display("FAIL refetch_pc got %h want %h", bus.adr, e); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_addi();
    test_branch();
    test_alu_corners();
    test_alu_random();
    test_jump();
    test_reg0_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
